// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a big-endian byte stream into 32-bit words
// and writes them to instruction memory, holding the CPU while loading.
module instr_mem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_words;
  logic [1:0]        r_byte;
  logic [DATA_W-9:0] r_asm;

  logic              w_bad;
  logic [CW-1:0]     w_n;
  logic              w_last;

  // header 0 encodes a full-depth load
  assign w_bad  = (int'(rx_data) > DEPTH);
  assign w_n    = (rx_data == 8'd0) ? CW'(DEPTH) : CW'(rx_data);
  assign w_last = (r_words == r_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_words  <= '0;
      r_byte   <= '0;
      r_asm    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (wr_en)
        wr_addr <= wr_addr + 1'b1;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_LEN;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            if (w_bad) begin
              r_state  <= S_DONE;
              err      <= 1'b1;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state <= S_LOAD;
              r_cnt   <= w_n;
              r_words <= '0;
              r_byte  <= '0;
              wr_addr <= '0;
            end
          end
        end
        S_LOAD: begin
          // finish on the edge that closes the last write strobe
          if (wr_en && w_last) begin
            r_state  <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else if (rx_valid && !w_last) begin
            r_asm  <= {r_asm[DATA_W-17:0], rx_data};
            r_byte <= r_byte + 2'd1;
            if (r_byte == 2'd3) begin
              wr_data <= {r_asm, rx_data};
              wr_en   <= 1'b1;
              r_words <= r_words + CW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed + random checks of instr_mem_loader
// against a word-list model of expected memory writes.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [31:0] words[64];

  instr_mem_loader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (wr_en)
      obs_q.push_back({wr_addr, wr_data});

  function automatic logic [63:0] outs();
    return {22'd0, wr_en, wr_addr, wr_data, cpu_hold, done, err};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input logic st);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = st;
    tick();
    rx_valid = 1'b0;
    start    = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // big-endian: byte 0 of a word is its most significant byte
  function automatic logic [7:0] byte_of(input int k, input int j);
    logic [31:0] w;
    w = words[k];
    return 8'(w >> (24 - 8 * j));
  endfunction

  task automatic expect_writes(input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++)
      exp_q.push_back({6'(k % 64), words[k]});
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, 64'(obs_q[i].a), 64'(exp_q[i].a));
      chk({tag, "_data"}, 64'(obs_q[i].d), 64'(exp_q[i].d));
    end
    obs_q.delete();
  endtask

  initial begin
    int hold_lost;
    int gap;

    // reset and idle
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_outs", outs(), 64'd0);
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      tick();
      chk("idle_outs", outs(), 64'd0);
    end
    rx_valid = 1'b0;
    chk("idle_writes", 64'(obs_q.size()), 64'd0);
    obs_q.delete();

    // two-word load
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h00000001;
    pulse_start();
    chk("hold_rise", 64'(cpu_hold), 64'd1);
    hold_lost = 0;
    send(8'h02, 0, 1'b0);
    if (cpu_hold !== 1'b1) hold_lost++;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++) begin
        send(byte_of(k, j), 0, 1'b0);
        if (cpu_hold !== 1'b1) hold_lost++;
      end
    chk("two_hold_lost", 64'(hold_lost), 64'd0);
    chk("two_last_wr", 64'(wr_en), 64'd1);
    chk("two_done_early", 64'(done), 64'd0);
    tick();
    chk("two_done", 64'({done, cpu_hold, wr_en}), 64'b100);
    chk("two_addr_after", 64'(wr_addr), 64'd2);
    expect_writes(2);
    cmp_writes("two");

    // full 64-word load
    for (int k = 0; k < 64; k++) words[k] = 32'(k);
    pulse_start();
    send(8'h00, 0, 1'b0);
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 4; j++)
        send(byte_of(k, j), 0, 1'b0);
    tick();
    chk("full_flags", 64'({done, err, cpu_hold}), 64'b100);
    chk("full_addr_wrap", 64'(wr_addr), 64'd0);
    expect_writes(64);
    cmp_writes("full");

    // bad header
    pulse_start();
    send(8'h41, 0, 1'b0);
    chk("bad_flags", 64'({err, done, cpu_hold}), 64'b110);
    for (int i = 0; i < 8; i++)
      send(8'($urandom), 0, 1'b0);
    chk("bad_held", 64'({err, done}), 64'b11);
    chk("bad_writes", 64'(obs_q.size()), 64'd0);
    obs_q.delete();

    // gapped bytes, header with start ignored, mid-load starts
    for (int k = 0; k < 3; k++) words[k] = $urandom;
    send(8'h01, 0, 1'b1);
    send(8'h03, $urandom_range(0, 5), 1'b0);
    pulse_start();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) begin
        gap = (k == 2 && j == 3) ? 0 : int'($urandom_range(0, 5));
        send(byte_of(k, j), gap, (j == 1));
      end
    chk("gap_last_wr", 64'(wr_en), 64'd1);
    tick();
    chk("gap_done", 64'({done, err, cpu_hold}), 64'b100);
    expect_writes(3);
    cmp_writes("gap");

    // reset after 6 payload bytes of an N=4 load
    for (int k = 0; k < 4; k++) words[k] = $urandom;
    pulse_start();
    send(8'h04, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      send(byte_of(i / 4, i % 4), 0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_outs", outs(), 64'd0);
    expect_writes(1);
    cmp_writes("rst_pre");
    words[0] = $urandom;
    pulse_start();
    send(8'h01, 0, 1'b0);
    for (int j = 0; j < 4; j++)
      send(byte_of(0, j), 0, 1'b0);
    tick();
    chk("rst_new_done", 64'({done, err, cpu_hold}), 64'b100);
    expect_writes(1);
    cmp_writes("rst_new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Writes a program image into the 64 × 32-bit instruction memory from a byte stream supplied by the UART receiver. It assembles big-endian bytes into 32-bit words and issues single-cycle write strobes to the memory's write port at consecutive word addresses. It holds the processor in reset while a load is in progress. The loader is the write-side counterpart of the combinational instruction-fetch read port.

## Interface
- ADDR_W, 6: word-address width; memory depth is 2^ADDR_W = 64 words.
- DATA_W, 32: word width; must equal 4 bytes.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- rx_data  in  8  received byte; valid only when rx_valid = 1.
- rx_valid  in  1  one-cycle strobe per received byte; back-to-back cycles are allowed.
- wr_en  out  1  write strobe to the instruction memory, one cycle per word.
- wr_addr  out  ADDR_W  word address for the write.
- wr_data  out  DATA_W  word to write.
- cpu_hold  out  1  processor hold/reset request; high while loading.
- done  out  1  load finished; held until the next start or reset.
- err  out  1  bad length header; held until the next start or reset.

## Operation
- States: IDLE, LEN, LOAD, DONE.
- IDLE:
  - start moves the FSM to LEN.
  - rx_valid is ignored, including when it arrives in the same cycle as start.
- LEN: the first accepted byte is the word count N.
  - Byte value 0 means N = 64.
  - Values 1..64 are used as given.
  - Values 65..255 set err = 1, perform no writes, and go to DONE.
  - A valid header clears the word counter, byte counter and address, then goes to LOAD.
- LOAD: each accepted byte shifts into the assembly register, MSB first: word = {b0, b1, b2, b3}.
  - Byte counter (2 bits) wraps 3→0.
  - When the 4th byte is accepted, the word is registered to wr_data, wr_en pulses and the word counter increments.
  - After the write, wr_addr increments and wraps modulo 64.
  - The write of word N-1 transitions the FSM to DONE.
- DONE: done = 1, cpu_hold = 0. start re-enters LEN and clears done and err.
- start in LEN or LOAD is ignored; a load cannot be restarted mid-stream except by reset.
- Reset mid-load:
  - Returns to IDLE next edge with all outputs at reset values.
  - Bytes and partial words already captured are discarded.
  - Memory words already written are not undone.

## Timing
- Reset values: wr_en = 0, wr_addr = 0, wr_data = 0, cpu_hold = 0, done = 0, err = 0, state = IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- cpu_hold:
  - Rises the cycle after start is sampled in IDLE/DONE.
  - Stays high through LEN and LOAD.
  - Falls in the same cycle done rises.
- Write latency: wr_en is high exactly one cycle, the cycle after the edge that samples the 4th rx_valid of a word. wr_addr and wr_data are stable during that cycle.
- Address sequencing:
  - wr_addr advances on the edge that ends the wr_en cycle.
  - The first write of a load uses address 0.
  - The final write of a 64-word load uses address 63; wr_addr then wraps to 0.
- done rises on the edge that ends the final wr_en cycle, so it is first high the cycle after the last write.
- err rises one cycle after the bad header byte is sampled, together with done. wr_en never pulses in that load.
- Maximum input rate is one byte per cycle, so the minimum load time is 1 + 4N cycles after LEN is entered.
- rx_valid in DONE is ignored.

## Test plan
- Reset then idle: hold reset 2 cycles, then run 10 idle cycles with random rx_valid -> all outputs 0, no wr_en.
- Two-word load:
  - Stimulus: start; bytes 02, DE,AD,BE,EF, 00,00,00,01, one per cycle.
  - Response: wr_en at addr 0 with DEADBEEF, then at addr 1 with 00000001. cpu_hold is high from the cycle after start until done rises. done = 1 one cycle after the 2nd write.
- Full load:
  - Stimulus: header 00, then 64 words where word k = k.
  - Response: 64 writes at addresses 0..63 with data 0..63. wr_addr = 0 afterwards, done = 1, err = 0.
- Bad header: start, byte 41 (hex) -> err = 1 and done = 1 one cycle later; zero wr_en pulses; subsequent bytes ignored.
- Gapped bytes and ignored inputs:
  - Stimulus: random 0–5 idle cycles between bytes for N = 3; also start pulses and the header sent in the same cycle as start.
  - Response: that header byte is ignored; writes are identical to the back-to-back case; start pulses mid-load have no effect.
- Reset mid-load:
  - Stimulus: assert reset after 6 payload bytes of an N = 4 load, then start a new N = 1 load.
  - Response: exactly 1 write before reset. After reset, the new load writes at addr 0 and no stale partial word appears.
